// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core runahead logic.
package mips_core_pkg;

   localparam int unsigned ADDR_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ENTER,
      RUNAHEAD,
      EXIT
   } runahead_state_t;

endpackage

// File: rtl/runahead_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/runahead_sequencer.sv
// Runahead episode sequencer: waits out a d-cache miss, checkpoints, runs ahead,
// then flushes, restores and redirects fetch to the stalled load.
module runahead_sequencer
   import mips_core_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
   parameter int unsigned ENTRY_DELAY = 4,
   parameter int unsigned MAX_CYCLES  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_load_miss,
   input  logic [ADDR_WIDTH-1:0] mem_pc,
   input  logic                  miss_done,
   output logic                  runahead_mode,
   output logic                  rf_checkpoint,
   output logic                  rf_restore,
   output logic                  flush_all,
   output logic                  exit_runahead,
   output logic                  load_pc_valid,
   output logic [ADDR_WIDTH-1:0] load_pc,
   output logic [15:0]           episode_count,
   output logic [31:0]           runahead_cycles
);

   localparam int unsigned WCNT_W = $clog2(ENTRY_DELAY + 1);
   localparam int unsigned RCNT_W = $clog2(MAX_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ENTRY_DELAY - 1);
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(MAX_CYCLES - 1);

   runahead_state_t       state;
   logic [WCNT_W-1:0]     wcnt;
   logic [RCNT_W-1:0]     rcnt;
   logic [ADDR_WIDTH-1:0] ckpt_pc;
   logic                  done_pend;
   logic                  blocked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wcnt      <= '0;
         ckpt_pc   <= '0;
         load_pc   <= '0;
         done_pend <= 1'b0;
         blocked   <= 1'b0;
      end else begin
         if (miss_done) begin
            blocked <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (mem_load_miss && !(blocked && (mem_pc == ckpt_pc))) begin
                  state <= WAIT;
                  wcnt  <= WCNT_W'(1);
               end
            end
            WAIT: begin
               if (miss_done || !mem_load_miss) begin
                  state <= IDLE;
               end else if (wcnt == WCNT_LAST) begin
                  state   <= ENTER;
                  ckpt_pc <= mem_pc;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            ENTER: begin
               if (miss_done) begin
                  done_pend <= 1'b1;
               end
               state <= RUNAHEAD;
            end
            RUNAHEAD: begin
               // A refill arriving on the timeout cycle counts as a normal exit.
               if (miss_done || done_pend) begin
                  state   <= EXIT;
                  load_pc <= ckpt_pc;
               end else if (rcnt == RCNT_LAST) begin
                  state   <= EXIT;
                  load_pc <= ckpt_pc;
                  blocked <= 1'b1;
               end
            end
            EXIT: begin
               done_pend <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign runahead_mode = (state == ENTER) || (state == RUNAHEAD);
   assign rf_checkpoint = (state == ENTER);
   assign rf_restore    = (state == EXIT);
   assign flush_all     = (state == EXIT);
   assign exit_runahead = (state == EXIT);
   assign load_pc_valid = (state == EXIT);

   sat_counter #(.WIDTH(RCNT_W)) u_rcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state == RUNAHEAD),
      .clr   (state == ENTER),
      .count (rcnt)
   );

   sat_counter #(.WIDTH(16)) u_episode_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state == ENTER),
      .clr   (1'b0),
      .count (episode_count)
   );

   sat_counter #(.WIDTH(32)) u_runahead_cycles (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state == RUNAHEAD),
      .clr   (1'b0),
      .count (runahead_cycles)
   );

endmodule

// File: tb/tb_runahead_sequencer.sv
// Self-checking bench for runahead_sequencer: directed table, corner sequences, random traffic.
module tb_runahead_sequencer;

   localparam int ED   = 4;
   localparam int MAXC = 24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_load_miss = 1'b0;
   logic [15:0] mem_pc = '0;
   logic        miss_done = 1'b0;
   logic        runahead_mode, rf_checkpoint, rf_restore, flush_all;
   logic        exit_runahead, load_pc_valid;
   logic [15:0] load_pc;
   logic [15:0] episode_count;
   logic [31:0] runahead_cycles;

   runahead_sequencer #(
      .ADDR_WIDTH  (16),
      .ENTRY_DELAY (ED),
      .MAX_CYCLES  (MAXC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_load_miss   (mem_load_miss),
      .mem_pc          (mem_pc),
      .miss_done       (miss_done),
      .runahead_mode   (runahead_mode),
      .rf_checkpoint   (rf_checkpoint),
      .rf_restore      (rf_restore),
      .flush_all       (flush_all),
      .exit_runahead   (exit_runahead),
      .load_pc_valid   (load_pc_valid),
      .load_pc         (load_pc),
      .episode_count   (episode_count),
      .runahead_cycles (runahead_cycles)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: miss streak length, age within an episode, and event flags.
   int          m_streak;   // consecutive qualifying miss cycles seen (0 = none)
   int          m_age;      // -1 outside episode, 0 checkpoint cycle, k = k-th speculative cycle
   bit          m_exit;     // recovery cycle in progress
   bit          m_pend;
   bit          m_blk;
   logic [15:0] m_ckpt;
   logic [15:0] m_lpc;
   longint      m_ep;
   longint      m_rc;

   function automatic void chk(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_streak = 0; m_age = -1; m_exit = 0; m_pend = 0; m_blk = 0;
      m_ckpt = '0; m_lpc = '0; m_ep = 0; m_rc = 0;
   endfunction

   function automatic void model_step(bit miss, logic [15:0] pc, bit done);
      bit blk_old = m_blk;
      if (done) m_blk = 0;
      if (m_exit) begin
         m_exit = 0;
         m_pend = 0;
      end else if (m_age == 0) begin
         if (m_ep < 65535) m_ep++;
         if (done) m_pend = 1;
         m_age = 1;
      end else if (m_age >= 1) begin
         if (m_rc < 64'hFFFF_FFFF) m_rc++;
         if (done || m_pend || m_age == MAXC) begin
            if (!(done || m_pend)) m_blk = 1;
            m_exit = 1;
            m_lpc  = m_ckpt;
            m_age  = -1;
         end else begin
            m_age++;
         end
      end else if (m_streak == 0) begin
         if (miss && !(blk_old && pc == m_ckpt)) m_streak = 1;
      end else if (done || !miss) begin
         m_streak = 0;
      end else begin
         m_streak++;
         if (m_streak == ED) begin
            m_streak = 0;
            m_age    = 0;
            m_ckpt   = pc;
         end
      end
   endfunction

   task automatic check_model();
      chk("runahead_mode",   runahead_mode,   m_age >= 0);
      chk("rf_checkpoint",   rf_checkpoint,   m_age == 0);
      chk("rf_restore",      rf_restore,      m_exit);
      chk("flush_all",       flush_all,       m_exit);
      chk("exit_runahead",   exit_runahead,   m_exit);
      chk("load_pc_valid",   load_pc_valid,   m_exit);
      chk("load_pc",         load_pc,         m_lpc);
      chk("episode_count",   episode_count,   m_ep);
      chk("runahead_cycles", runahead_cycles, m_rc);
   endtask

   task automatic step(input bit miss, input logic [15:0] pc, input bit done);
      mem_load_miss = miss;
      mem_pc        = pc;
      miss_done     = done;
      @(posedge clk);
      model_step(miss, pc, done);
      #1;
      check_model();
   endtask

   task automatic enter(input logic [15:0] pc);
      int n = 0;
      step(1'b1, pc, 1'b0);
      while (!rf_checkpoint && n < 12) begin
         step(1'b1, pc, 1'b0);
         n++;
      end
      chk("enter_reached", rf_checkpoint, 1);
   endtask

   typedef struct {
      bit          miss;
      logic [15:0] pc;
      bit          done;
      bit          rm;
      bit          ck;
      bit          ex;
      int          ep;
      int          rc;
      logic [15:0] lpc;
   } vec_t;

   vec_t tbl[11];

   initial begin
      longint rc0, ep0;
      int     n;
      bit     seen;
      bit     cur_miss;
      logic [15:0] cur_pc;
      logic [15:0] pcs[3];

      tbl[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[2]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[3]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[4]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[5]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[6]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
      tbl[7]  = '{1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 16'h0000};
      tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'h0000};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 16'h0040};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 16'h0040};

      #1 rst_n = 1'b0;
      model_reset();
      #11;
      check_model();
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].miss, tbl[i].pc, tbl[i].done);
         chk($sformatf("tbl%0d_rm", i),  runahead_mode,   tbl[i].rm);
         chk($sformatf("tbl%0d_ck", i),  rf_checkpoint,   tbl[i].ck);
         chk($sformatf("tbl%0d_ex", i),  flush_all,       tbl[i].ex);
         chk($sformatf("tbl%0d_ep", i),  episode_count,   tbl[i].ep);
         chk($sformatf("tbl%0d_rc", i),  runahead_cycles, tbl[i].rc);
         chk($sformatf("tbl%0d_lpc", i), load_pc,         tbl[i].lpc);
      end

      // miss_done 20 cycles after the checkpoint cycle
      rc0 = runahead_cycles; ep0 = episode_count;
      enter(16'h0040);
      repeat (20) step(1'b1, 16'h0040, 1'b0);
      chk("long_still_ra", runahead_mode, 1);
      step(1'b1, 16'h0040, 1'b1);
      chk("long_exit", load_pc_valid, 1);
      chk("long_lpc", load_pc, 16'h0040);
      chk("long_rc", runahead_cycles - rc0, 20);
      chk("long_ep", episode_count - ep0, 1);
      step(1'b0, 16'h0000, 1'b0);

      // miss_done during the checkpoint cycle
      rc0 = runahead_cycles;
      enter(16'h0044);
      step(1'b0, 16'h0000, 1'b1);
      chk("enter_done_ra", runahead_mode, 1);
      step(1'b0, 16'h0000, 1'b0);
      chk("enter_done_exit", flush_all, 1);
      chk("enter_done_rc", runahead_cycles - rc0, 1);
      step(1'b0, 16'h0000, 1'b0);

      // timeout, then blocked re-entry on the same PC until a refill
      enter(16'h0080);
      n = 0;
      while (n < 60) begin
         step(1'b1, 16'h0080, 1'b0);
         n++;
         if (flush_all) break;
      end
      chk("timeout_len", n, MAXC + 1);
      chk("timeout_lpc", load_pc, 16'h0080);
      seen = 0;
      repeat (10) begin
         step(1'b1, 16'h0080, 1'b0);
         if (rf_checkpoint || runahead_mode) seen = 1;
      end
      chk("blocked_reentry", seen, 0);
      step(1'b1, 16'h0080, 1'b1);
      enter(16'h0080);
      step(1'b0, 16'h0000, 1'b1);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0);

      // miss_done coinciding with the timeout cycle is a normal exit
      enter(16'h00A0);
      repeat (MAXC) step(1'b0, 16'h0000, 1'b0);
      chk("simul_still_ra", runahead_mode, 1);
      step(1'b0, 16'h0000, 1'b1);
      chk("simul_exit", flush_all, 1);
      step(1'b0, 16'h0000, 1'b0);
      enter(16'h00A0);
      step(1'b0, 16'h0000, 1'b1);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0);

      // asynchronous reset in the middle of runahead
      enter(16'h00B0);
      repeat (3) step(1'b0, 16'h0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_rm", runahead_mode, 0);
      chk("rst_ep", episode_count, 0);
      chk("rst_rc", runahead_cycles, 0);
      chk("rst_lpc", load_pc, 0);
      #2 rst_n = 1'b1;
      step(1'b0, 16'h0000, 1'b0);
      chk("rst_no_pulse", {rf_checkpoint, rf_restore, flush_all, exit_runahead, load_pc_valid}, 0);

      // random traffic against the model
      pcs[0] = 16'h0040; pcs[1] = 16'h0080; pcs[2] = 16'h00C0;
      cur_miss = 1'b0;
      cur_pc   = pcs[0];
      repeat (3000) begin
         if ($urandom_range(0, 9) == 0) cur_miss = !cur_miss;
         if ($urandom_range(0, 7) == 0) cur_pc = pcs[$urandom_range(0, 2)];
         step(cur_miss, cur_pc, $urandom_range(0, 39) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/runahead_sequencer.md
# runahead_sequencer

Sequences runahead execution for the 5-stage MIPS core. Detects a load stalled in MEM on a d-cache miss and, after a programmable delay, checkpoints the load PC and the register file, then puts the pipeline into runahead mode. On miss resolution or timeout it flushes the pipeline, restores architectural state and redirects fetch to the checkpointed load. It sits beside `hazard_controller` and drives the runahead/recovery controls consumed by fetch, `reg_file`, `d_cache` and the pipeline registers.

## Interface
Parameters:
- `ADDR_WIDTH`, `` `ADDR_WIDTH ``: PC/byte-address width.
- `ENTRY_DELAY`, 4: consecutive miss cycles required before entering runahead; legal range ≥2.
- `MAX_CYCLES`, 256: runahead timeout in cycles; legal range ≥1.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `mem_load_miss`  in  1  load in MEM is stalled on a d-cache miss.
- `mem_pc`  in  ADDR_WIDTH  PC of the instruction in MEM.
- `miss_done`  in  1  one-cycle pulse: the outstanding d-cache refill has completed.
- `runahead_mode`  out  1  pipeline is executing speculatively; suppress retirement.
- `rf_checkpoint`  out  1  pulse: shadow register file captures architectural state.
- `rf_restore`  out  1  pulse: architectural register file is restored from the shadow.
- `flush_all`  out  1  pulse: flush IF/DEC/EX/MEM pipeline registers.
- `exit_runahead`  out  1  pulse to `d_cache`: drop runahead-only state.
- `load_pc_valid`  out  1  pulse: redirect fetch.
- `load_pc`  out  ADDR_WIDTH  redirect target (the checkpoint PC).
- `episode_count`  out  16  number of runahead entries (saturating).
- `runahead_cycles`  out  32  total cycles spent in RUNAHEAD (saturating).

## Operation
- States: IDLE, WAIT, ENTER, RUNAHEAD, EXIT. Outputs are Moore-decoded from the state register, except the counters and `load_pc`, which are registers.
- IDLE: if `mem_load_miss` is high and the entry is not blocked, go to WAIT with `wcnt`=1.
- WAIT:
  - If `miss_done` is high or `mem_load_miss` is low, go to IDLE.
  - Otherwise, if `wcnt`==ENTRY_DELAY-1, go to ENTER and capture `ckpt_pc`←`mem_pc`.
  - Otherwise increment `wcnt`.
- ENTER (1 cycle):
  - `runahead_mode`=1 and `rf_checkpoint`=1.
  - `episode_count` increments (saturating at 0xFFFF).
  - `rcnt` clears.
  - A `miss_done` pulse in this cycle sets `done_pend`.
  - Next state is RUNAHEAD.
- RUNAHEAD:
  - `runahead_mode`=1.
  - `rcnt` and `runahead_cycles` increment each cycle (saturating).
  - `miss_done` or `done_pend` moves to EXIT.
  - Otherwise `rcnt`==MAX_CYCLES-1 moves to EXIT with `timeout`=1.
- EXIT (1 cycle):
  - `runahead_mode`=0.
  - `flush_all`, `rf_restore`, `exit_runahead` and `load_pc_valid` are all 1, with `load_pc`=`ckpt_pc`.
  - `done_pend` clears. Next state is IDLE.
- Timeout block: on timeout exit, set `blocked`=1. While `blocked` and `mem_pc`==`ckpt_pc`, IDLE does not leave. `blocked` clears on any `miss_done`.
- Simultaneous events:
  - `miss_done` together with timeout in RUNAHEAD is treated as a normal exit; `blocked` stays 0.
  - `mem_load_miss` dropping during ENTER/RUNAHEAD is ignored; only `miss_done` or timeout ends runahead.
- Reset (asynchronous, any state):
  - Go to IDLE.
  - All outputs, `wcnt`, `rcnt`, `ckpt_pc`, `done_pend`, `blocked`, `episode_count` and `runahead_cycles` go to 0.

## Timing
- A miss first seen high at cycle t and held through t+ENTRY_DELAY-1 puts the FSM in ENTER during cycle t+ENTRY_DELAY.
- RUNAHEAD runs from t+ENTRY_DELAY+1.
- `miss_done` at cycle m while in RUNAHEAD gives EXIT in cycle m+1 and IDLE in m+2.
- Timeout: EXIT occurs MAX_CYCLES cycles after RUNAHEAD is first entered.
- All pulse outputs last exactly one cycle.
- Minimum episode length is ENTER + 1 RUNAHEAD + EXIT = 3 cycles.
- No combinational path from any input to any output.

## Structure
- `runahead_state_t` enum (IDLE, WAIT, ENTER, RUNAHEAD, EXIT) lives in `mips_core_pkg`.
- One sub-module, `sat_counter` (parameterised width, inc/clr, saturating). It is instantiated for `rcnt`, `episode_count` and `runahead_cycles`.
- Integration in `mips_core`: `runahead_mode` replaces the runahead output of `hazard_controller`. `load_pc_valid`/`load_pc` are OR-merged into `load_pc_ifc` with priority over branch redirects.

## Test plan
- ENTRY_DELAY=4: `mem_load_miss` high for 3 cycles, then low → stays IDLE/WAIT, no `rf_checkpoint`, `episode_count`=0.
- `mem_load_miss` held with `mem_pc`=0x0040 and `miss_done` pulsed 20 cycles after entry → ENTER at t+4, `runahead_cycles`=20, EXIT pulses with `load_pc`=0x0040, `episode_count`=1.
- MAX_CYCLES=8, no `miss_done` → EXIT exactly 8 cycles after entering RUNAHEAD. Re-presenting `mem_pc`=0x0040 with `mem_load_miss` high causes no re-entry until `miss_done`; afterwards entry works again.
- `miss_done` pulsed during the ENTER cycle → exactly one RUNAHEAD cycle, then EXIT; `runahead_cycles`=1.
- `rst_n` asserted mid-RUNAHEAD (asynchronously, between edges) → `runahead_mode` and counters read 0 immediately; after release, IDLE with no pulse outputs.
- `miss_done` and timeout in the same RUNAHEAD cycle → normal EXIT with `blocked`=0; the same `mem_pc` can re-enter on its next miss.
